// File: rtl/microcode_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : microcode_pipeline
// Purpose  : Four-stage (s0..s3) in-order microcode pipeline. Each stage is a
//            single register of {valid, microcode, rd, rs1, rs2}. Detects
//            read-after-write hazards between the word in s0 and
//            register-writing words in s1..s3 and stalls s0 (injecting a
//            bubble into s1) until the producer has retired. A taken jump
//            resolved in s2 (flush) squashes s0..s2 while the old s2 word
//            still moves into s3. Stall cycles are counted in a saturating
//            16-bit counter.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - upstream decoder handshake
//            in_microcode, in_rd, in_rs1, in_rs2 - incoming word and indices
//            flush               - squash s0..s2 (jump taken in s2)
//            sN_microcode/sN_valid (N=0..3) - per-stage word and valid flag
//            s3_rd               - write-back destination index
//            stall_count         - saturating hazard-stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module microcode_pipeline #(
    parameter int UCODE_W = 22,
    parameter int REG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UCODE_W-1:0] in_microcode,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2,
    input  logic               flush,
    output logic [UCODE_W-1:0] s0_microcode,
    output logic [UCODE_W-1:0] s1_microcode,
    output logic [UCODE_W-1:0] s2_microcode,
    output logic [UCODE_W-1:0] s3_microcode,
    output logic               s0_valid,
    output logic               s1_valid,
    output logic               s2_valid,
    output logic               s3_valid,
    output logic [REG_W-1:0]   s3_rd,
    output logic [15:0]        stall_count
);

    // Microcode control-bit positions used by the hazard logic.
    localparam int          c_BIT_RS1_USE = 0;
    localparam int          c_BIT_RS2_USE = 1;
    localparam int          c_BIT_REG_WE  = 20;
    localparam int          c_NUM_STAGES  = 4;
    localparam logic [15:0] c_CNT_MAX     = 16'hFFFF;

    typedef struct packed {
        logic               valid;
        logic [UCODE_W-1:0] microcode;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
    } stage_t;

    // A bubble is all-zero so every control bit it drives is inactive.
    localparam stage_t c_BUBBLE = '0;

    stage_t r_stage_q [c_NUM_STAGES];
    stage_t w_stage_d [c_NUM_STAGES];

    logic [15:0] r_stall_count_q;
    logic [15:0] w_stall_count_d;

    stage_t                    w_in_stage;
    logic [c_NUM_STAGES-1:1]   w_hazard;
    logic                      w_stall;
    logic                      w_accept;

    // ------------------------------------------------------------------
    // Hazard detection: s0 reads a register that an older in-flight word
    // (s1..s3) will write. Register 0 is never a real dependency.
    // ------------------------------------------------------------------
    for (genvar k = 1; k < c_NUM_STAGES; k++) begin : g_hazard
        assign w_hazard[k] = r_stage_q[k].valid
                          && r_stage_q[k].microcode[c_BIT_REG_WE]
                          && (r_stage_q[k].rd != '0)
                          && ((r_stage_q[0].microcode[c_BIT_RS1_USE]
                               && (r_stage_q[0].rs1 == r_stage_q[k].rd))
                           || (r_stage_q[0].microcode[c_BIT_RS2_USE]
                               && (r_stage_q[0].rs2 == r_stage_q[k].rd)));
    end

    assign w_stall  = r_stage_q[0].valid && (|w_hazard);
    assign in_ready = (!r_stage_q[0].valid || !w_stall) && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_in_stage = '{valid:     1'b1,
                          microcode: in_microcode,
                          rd:        in_rd,
                          rs1:       in_rs1,
                          rs2:       in_rs2};

    // ------------------------------------------------------------------
    // Next-state: flush beats stall; s3 always retires (no backpressure).
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < c_NUM_STAGES; i++) begin
            w_stage_d[i] = r_stage_q[i];
        end
        w_stall_count_d = r_stall_count_q;

        if (flush) begin
            // The jump lives in s2 and still retires; everything younger dies.
            w_stage_d[0] = c_BUBBLE;
            w_stage_d[1] = c_BUBBLE;
            w_stage_d[2] = c_BUBBLE;
            w_stage_d[3] = r_stage_q[2];
        end else begin
            w_stage_d[3] = r_stage_q[2];
            w_stage_d[2] = r_stage_q[1];
            if (w_stall) begin
                w_stage_d[1] = c_BUBBLE;
                w_stage_d[0] = r_stage_q[0];
                if (r_stall_count_q != c_CNT_MAX) begin
                    w_stall_count_d = r_stall_count_q + 16'd1;
                end
            end else begin
                w_stage_d[1] = r_stage_q[0];
                w_stage_d[0] = w_accept ? w_in_stage : c_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_stage_q[i] <= c_BUBBLE;
            end
            r_stall_count_q <= '0;
        end else begin
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_stage_q[i] <= w_stage_d[i];
            end
            r_stall_count_q <= w_stall_count_d;
        end
    end

    // Source indices of the retiring word have no consumer past s3.
    logic w_unused_s3_src;
    assign w_unused_s3_src = ^{r_stage_q[3].rs1, r_stage_q[3].rs2};

    assign s0_microcode = r_stage_q[0].microcode;
    assign s1_microcode = r_stage_q[1].microcode;
    assign s2_microcode = r_stage_q[2].microcode;
    assign s3_microcode = r_stage_q[3].microcode;
    assign s0_valid     = r_stage_q[0].valid;
    assign s1_valid     = r_stage_q[1].valid;
    assign s2_valid     = r_stage_q[2].valid;
    assign s3_valid     = r_stage_q[3].valid;
    assign s3_rd        = r_stage_q[3].rd;
    assign stall_count  = r_stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_microcode_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_microcode_pipeline
// Purpose  : Directed, table-driven bench for microcode_pipeline. Each table
//            record holds one cycle of inputs, the expected combinational
//            in_ready for those inputs, and the expected stage state after
//            the following clock edge. A hand-written sequence covers the
//            long saturation run and reset in the middle of a stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microcode_pipeline;

    localparam int UCODE_W = 22;
    localparam int REG_W   = 5;
    localparam int NV      = 45;

    // Test words. Bit 20 = register write, bit 0 = uses rs1, bit 1 = uses rs2.
    localparam logic [21:0] W1 = 22'h100010;
    localparam logic [21:0] W2 = 22'h100020;
    localparam logic [21:0] W3 = 22'h100030;
    localparam logic [21:0] W4 = 22'h100040;
    localparam logic [21:0] WA = 22'h100050;  // producer
    localparam logic [21:0] WB = 22'h000061;  // consumer via rs1
    localparam logic [21:0] WC = 22'h000070;  // independent
    localparam logic [21:0] WD = 22'h000080;  // rs1 match but bit0 clear
    localparam logic [21:0] WE = 22'h000092;  // consumer via rs2
    localparam logic [21:0] WP = 22'h100001;  // producer and consumer of r5

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [UCODE_W-1:0] in_microcode;
    logic [REG_W-1:0]   in_rd, in_rs1, in_rs2;
    logic               flush;
    logic [UCODE_W-1:0] s0_microcode, s1_microcode, s2_microcode, s3_microcode;
    logic               s0_valid, s1_valid, s2_valid, s3_valid;
    logic [REG_W-1:0]   s3_rd;
    logic [15:0]        stall_count;

    always #5 clk = ~clk;

    microcode_pipeline #(.UCODE_W(UCODE_W), .REG_W(REG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_microcode (in_microcode),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .flush        (flush),
        .s0_microcode (s0_microcode),
        .s1_microcode (s1_microcode),
        .s2_microcode (s2_microcode),
        .s3_microcode (s3_microcode),
        .s0_valid     (s0_valid),
        .s1_valid     (s1_valid),
        .s2_valid     (s2_valid),
        .s3_valid     (s3_valid),
        .s3_rd        (s3_rd),
        .stall_count  (stall_count)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [21:0] mc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        fl;
        logic        e_rdy;
        logic [3:0]  e_v;     // {s3,s2,s1,s0} valid after the edge
        logic [4:0]  e_rd;    // s3_rd after the edge
        logic [21:0] e_mc;    // s3_microcode after the edge
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(input logic r, input logic iv,
                                input logic [21:0] mc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic fl, input logic e_rdy,
                                input logic [3:0] e_v, input logic [4:0] e_rd,
                                input logic [21:0] e_mc, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = r;   v.iv = iv;   v.mc = mc;   v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.fl = fl;   v.e_rdy = e_rdy;
        v.e_v = e_v; v.e_rd = e_rd; v.e_mc = e_mc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_v,
                               input logic [4:0] e_rd, input logic [21:0] e_mc,
                               input logic [15:0] e_cnt);
        logic [21:0] mcs [4];
        mcs[0] = s0_microcode; mcs[1] = s1_microcode;
        mcs[2] = s2_microcode; mcs[3] = s3_microcode;
        chk({tag, " valid"}, {28'd0, s3_valid, s2_valid, s1_valid, s0_valid}, {28'd0, e_v});
        chk({tag, " s3_rd"}, {27'd0, s3_rd}, {27'd0, e_rd});
        chk({tag, " s3_mc"}, {10'd0, s3_microcode}, {10'd0, e_mc});
        chk({tag, " stall_count"}, {16'd0, stall_count}, {16'd0, e_cnt});
        for (int i = 0; i < 4; i++) begin
            if (!e_v[i]) begin
                chk($sformatf("%s s%0d bubble mc", tag, i), {10'd0, mcs[i]}, 32'd0);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        rst          = v.rst;
        in_valid     = v.iv;
        in_microcode = v.mc;
        in_rd        = v.rd;
        in_rs1       = v.rs1;
        in_rs2       = v.rs2;
        flush        = v.fl;
        #1;
        chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.e_rdy});
        @(posedge clk);
        #1;
        check_state(tag, v.e_v, v.e_rd, v.e_mc, v.e_cnt);
        n_vec++;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //             rst iv  mc  rd  rs1 rs2 fl rdy  valid    s3rd s3mc cnt
        tbl[0]  = mk(1, 1, W1, 1, 0, 0, 0, 1, 4'b0000, 0, '0, 0);
        tbl[1]  = mk(0, 1, W1, 1, 0, 0, 0, 1, 4'b0001, 0, '0, 0);
        tbl[2]  = mk(0, 1, W2, 2, 0, 0, 0, 1, 4'b0011, 0, '0, 0);
        tbl[3]  = mk(0, 1, W3, 3, 0, 0, 0, 1, 4'b0111, 0, '0, 0);
        tbl[4]  = mk(0, 1, W4, 4, 0, 0, 0, 1, 4'b1111, 1, W1, 0);
        tbl[5]  = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1110, 2, W2, 0);
        tbl[6]  = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1100, 3, W3, 0);
        tbl[7]  = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1000, 4, W4, 0);
        tbl[8]  = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 0);
        // RAW hazard via rs1: B waits for A (rd=5) to leave s3.
        tbl[9]  = mk(0, 1, WA, 5, 0, 0, 0, 1, 4'b0001, 0, '0, 0);
        tbl[10] = mk(0, 1, WB, 6, 5, 0, 0, 1, 4'b0011, 0, '0, 0);
        tbl[11] = mk(0, 1, WC, 7, 0, 0, 0, 0, 4'b0101, 0, '0, 1);
        tbl[12] = mk(0, 1, WC, 7, 0, 0, 0, 0, 4'b1001, 5, WA, 2);
        tbl[13] = mk(0, 1, WC, 7, 0, 0, 0, 0, 4'b0001, 0, '0, 3);
        tbl[14] = mk(0, 1, WC, 7, 0, 0, 0, 1, 4'b0011, 0, '0, 3);
        tbl[15] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0110, 0, '0, 3);
        tbl[16] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1100, 6, WB, 3);
        tbl[17] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1000, 7, WC, 3);
        tbl[18] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 3);
        // No stall: producer rd=0, then consumer with use-bit clear.
        tbl[19] = mk(0, 1, WA, 0, 0, 0, 0, 1, 4'b0001, 0, '0, 3);
        tbl[20] = mk(0, 1, WB, 6, 0, 0, 0, 1, 4'b0011, 0, '0, 3);
        tbl[21] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0110, 0, '0, 3);
        tbl[22] = mk(0, 1, WA, 5, 0, 0, 0, 1, 4'b1101, 0, WA, 3);
        tbl[23] = mk(0, 1, WD, 8, 5, 0, 0, 1, 4'b1011, 6, WB, 3);
        tbl[24] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0110, 0, '0, 3);
        // rs2 hazard against producer in s3: one stall cycle.
        tbl[25] = mk(0, 1, WE, 9, 0, 5, 0, 1, 4'b1101, 5, WA, 3);
        tbl[26] = mk(0, 0, '0, 0, 0, 0, 0, 0, 4'b1001, 8, WD, 4);
        tbl[27] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0010, 0, '0, 4);
        tbl[28] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0100, 0, '0, 4);
        tbl[29] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b1000, 9, WE, 4);
        tbl[30] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 4);
        // Flush with s0..s2 full; the offered W4 must be dropped.
        tbl[31] = mk(0, 1, W1, 1, 0, 0, 0, 1, 4'b0001, 0, '0, 4);
        tbl[32] = mk(0, 1, W2, 2, 0, 0, 0, 1, 4'b0011, 0, '0, 4);
        tbl[33] = mk(0, 1, W3, 3, 0, 0, 0, 1, 4'b0111, 0, '0, 4);
        tbl[34] = mk(0, 1, W4, 4, 0, 0, 1, 0, 4'b1000, 1, W1, 4);
        tbl[35] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 4);
        // Flush coinciding with a pending stall: no count increment.
        tbl[36] = mk(0, 1, W1, 1, 0, 0, 0, 1, 4'b0001, 0, '0, 4);
        tbl[37] = mk(0, 1, WA, 5, 0, 0, 0, 1, 4'b0011, 0, '0, 4);
        tbl[38] = mk(0, 1, WB, 6, 5, 0, 0, 1, 4'b0111, 0, '0, 4);
        tbl[39] = mk(0, 1, WC, 7, 0, 0, 1, 0, 4'b1000, 1, W1, 4);
        tbl[40] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 4);
        // Reset mid-stream discards in-flight words and clears the count.
        tbl[41] = mk(0, 1, W1, 1, 0, 0, 0, 1, 4'b0001, 0, '0, 4);
        tbl[42] = mk(0, 1, W2, 2, 0, 0, 0, 1, 4'b0011, 0, '0, 4);
        tbl[43] = mk(1, 1, W3, 3, 0, 0, 0, 1, 4'b0000, 0, '0, 0);
        tbl[44] = mk(0, 0, '0, 0, 0, 0, 0, 1, 4'b0000, 0, '0, 0);

        rst = 1'b1; in_valid = 1'b0; in_microcode = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; flush = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], i);
        end

        // Saturation: a stream of words that each read r5 and write r5 gives
        // a repeating pattern of 3 stall cycles then 1 free cycle. After the
        // n-th edge (n>=2) the count is 3*((n-2)/4) + min((n-2)%4, 3).
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_microcode = WP;
        in_rd = 5'd5; in_rs1 = 5'd5; in_rs2 = 5'd0; flush = 1'b0;
        for (int n = 1; n <= 87388; n++) begin
            @(posedge clk);
            #1;
            if (n == 5 || n == 6) begin
                chk($sformatf("sat n%0d", n), {16'd0, stall_count}, 32'd3);
                n_vec++;
            end
            if (n == 87380) begin
                chk("sat 0xFFFE", {16'd0, stall_count}, 32'h0000_FFFE);
                n_vec++;
            end
            if (n == 87381 || n == 87388) begin
                chk($sformatf("sat hold n%0d", n), {16'd0, stall_count}, 32'h0000_FFFF);
                n_vec++;
            end
        end

        // Next cycle is a stall cycle; reset lands in the middle of it.
        @(negedge clk);
        #1;
        chk("stalled before rst in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst mid-stall", 4'b0000, 5'd0, 22'd0, 16'd0);
        n_vec++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("in_ready after rst", {31'd0, in_ready}, 32'd1);
        n_vec++;
        @(posedge clk);
        #1;
        check_state("idle after rst", 4'b0000, 5'd0, 22'd0, 16'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microcode_pipeline.md
MICROCODE_PIPELINE -- requirements
Module: microcode_pipeline

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 Parameter UCODE_W, default 22: microcode word width.
REQ-003 Parameter REG_W, default 5: register-index width.
REQ-004 Port in_valid, input, width 1: upstream decoder presents a word.
REQ-005 Port in_ready, output, width 1: block accepts the word this cycle.
REQ-006 Port in_microcode, input, width UCODE_W: decoded microcode word.
REQ-007 Port in_rd / in_rs1 / in_rs2, input, width REG_W each: destination and source register indices.
REQ-008 Port flush, input, width 1: taken jump resolved in s2.
REQ-009 Port sN_microcode, output, width UCODE_W, for N=0..3: word held in stage N, feeding the stage-N decoder.
REQ-010 Port sN_valid, output, width 1, for N=0..3: stage N holds a real instruction.
REQ-011 Port s3_rd, output, width REG_W: write-back destination.
REQ-012 Port stall_count, output, width 16: saturating count of hazard-stall cycles.

Function
REQ-013 Stages s0->s1->s2->s3 SHALL each be one register of {valid, microcode, rd, rs1, rs2}, advancing one stage per cycle unless stalled.
REQ-014 A bubble SHALL be valid=0 with microcode=0, so every control bit, including reg_write_enable (bit 20) and mem_write_enable (bit 15), is deasserted.
REQ-015 Hazard: stall SHALL be asserted when s0_valid is set and, for some stage k in {1,2,3}, all of the following hold: sk_valid=1, sk bit 20=1, sk rd!=0, and either (s0 bit 0=1 and s0 rs1==sk rd) or (s0 bit 1=1 and s0 rs2==sk rd).
REQ-016 During stall, s0 SHALL hold, s1 SHALL load a bubble, and s2 and s3 SHALL advance normally.
REQ-017 in_ready SHALL equal (!s0_valid || !stall) && !flush, combinationally.
REQ-018 The input SHALL be accepted when in_valid && in_ready; the word loads into s0 next cycle.
REQ-019 When s0 advances and no word is accepted, s0 SHALL load a bubble.
REQ-020 flush SHALL take priority over stall: next cycle s0 and s1 SHALL be bubbles, s3 SHALL take the old s2, and the input SHALL NOT be accepted.
REQ-021 s2 SHALL also become a bubble after flush; the old s2 moves to s3 and no new instruction enters s2.
REQ-022 s3 SHALL retire each cycle with no backpressure from downstream.
REQ-023 Simultaneous stall and flush SHALL behave as flush only, and stall_count SHALL NOT increment.
REQ-024 stall_count SHALL increment by 1 on each cycle stall=1 && flush=0, and SHALL saturate at 0xFFFF without wrapping.
REQ-025 rd, rs1 and rs2 SHALL travel with their word; bubbles SHALL carry index 0.

Reset
REQ-026 While rst=1 at a clk edge, all stages SHALL load bubbles (valid=0, microcode=0, indices=0) and stall_count SHALL load 0.
REQ-027 Reset SHALL override flush, stall and input acceptance.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight words with no partial retire.

Verification
REQ-030 Reset, then 4 back-to-back independent words (rd=1..4, bits 0/1 clear) -> each appears at s3 exactly 3 cycles after acceptance, in order; stall_count=0.
REQ-031 Word A rd=5 with bit20=1, then word B rs1=5 with bit0=1 -> B holds in s0 for 3 cycles, in_ready=0 for those cycles, stall_count=3, and B reaches s1 the cycle after A retires from s3.
REQ-032 Same as REQ-031 but A rd=0, or B bit0=0 -> no stall; stall_count stays 0.
REQ-033 flush pulsed while s0, s1 and s2 are valid -> next cycle s0/s1/s2_valid=0, s3 holds the old s2 word, and in_valid is ignored that cycle.
REQ-034 flush in the same cycle as a pending hazard stall -> flush behaviour per REQ-020, stall_count unchanged.
REQ-035 Force 65540 stall cycles -> stall_count reads 0xFFFF; rst mid-stall -> all valid=0 and stall_count=0 next cycle.
